// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the 7-segment scan capture block.
// Segment patterns are active-low, bit6 = a ... bit0 = g.
package seg7_pkg;

    // Active-low segment patterns for decimal digits and blank
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Active-low digit enables, one per scanned position
    localparam logic [3:0] DIG_POS0 = 4'b1110;
    localparam logic [3:0] DIG_POS1 = 4'b1101;
    localparam logic [3:0] DIG_POS2 = 4'b1011;
    localparam logic [3:0] DIG_POS3 = 4'b0111;
    localparam logic [3:0] DIG_NONE = 4'b1111;

    localparam logic [3:0] BCD_BLANK = 4'hF;

    // What the enable lines say about the current cycle
    typedef enum logic [1:0] {
        DK_IDLE   = 2'd0,
        DK_SAMPLE = 2'd1,
        DK_BAD    = 2'd2
    } dig_kind_e;

    typedef struct packed {
        dig_kind_e  kind;
        logic [1:0] pos;
    } dig_class_t;

    // Map the enable pattern to a sample position, idle, or an illegal pattern
    function automatic dig_class_t classify_digit(input logic [3:0] d);
        dig_class_t r;
        r.kind = DK_BAD;
        r.pos  = 2'd0;
        case (d)
            DIG_POS0: begin r.kind = DK_SAMPLE; r.pos = 2'd0; end
            DIG_POS1: begin r.kind = DK_SAMPLE; r.pos = 2'd1; end
            DIG_POS2: begin r.kind = DK_SAMPLE; r.pos = 2'd2; end
            DIG_POS3: begin r.kind = DK_SAMPLE; r.pos = 2'd3; end
            DIG_NONE: r.kind = DK_IDLE;
            default:  r.kind = DK_BAD;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational decode of an active-low segment pattern into a 4-bit code.
// Blank decodes to 4'hF; any pattern that is neither a digit nor blank is illegal.
module seg7_to_bcd
    import seg7_pkg::*;
(
    input  logic [6:0] display,
    output logic [3:0] code,
    output logic       illegal
);

    // Table lookup against the package segment constants
    always_comb begin
        code    = BCD_BLANK;
        illegal = 1'b0;
        case (display)
            SEG_0:     code = 4'd0;
            SEG_1:     code = 4'd1;
            SEG_2:     code = 4'd2;
            SEG_3:     code = 4'd3;
            SEG_4:     code = 4'd4;
            SEG_5:     code = 4'd5;
            SEG_6:     code = 4'd6;
            SEG_7:     code = 4'd7;
            SEG_8:     code = 4'd8;
            SEG_9:     code = 4'd9;
            SEG_BLANK: code = BCD_BLANK;
            default:   illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_scan_capture.sv
// Reconstructs four BCD digits from a multiplexed, active-low 7-segment scan.
// A position's output changes only after CONFIRM identical consecutive samples
// of that position; lost scan activity is flagged through stale.
module seg7_scan_capture
    import seg7_pkg::*;
#(
    parameter int CONFIRM = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] digit,
    input  logic [6:0] display,
    output logic [3:0] bcd0,
    output logic [3:0] bcd1,
    output logic [3:0] bcd2,
    output logic [3:0] bcd3,
    output logic [3:0] valid,
    output logic       upd,
    output logic [1:0] upd_pos,
    output logic       err,
    output logic       stale
);

    localparam int CW = $clog2(CONFIRM + 1);
    localparam int TW = $clog2(TIMEOUT);

    localparam logic [CW-1:0] CNT_FULL = CW'(CONFIRM);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TO_WARN  = TW'(TIMEOUT - 2);

    // Count of matching samples, saturating once confirmation is reached
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
        return (c >= CNT_FULL) ? CNT_FULL : c + CW'(1);
    endfunction

    logic [3:0]    bcd_q  [4];
    logic [3:0]    cand_q [4];
    logic [CW-1:0] cnt_q  [4];
    logic [TW-1:0] tcnt_q;

    dig_class_t    cls_p0;
    logic [1:0]    pos_p0;
    logic [3:0]    code_p0;
    logic          seg_bad_p0;
    logic          sample_p0;
    logic          vld_p0;
    logic          seg_err_p0;
    logic          dig_err_p0;
    logic [CW-1:0] cnt_nxt_p0;
    logic          commit_p0;
    logic          expire_p0;

    assign bcd0 = bcd_q[0];
    assign bcd1 = bcd_q[1];
    assign bcd2 = bcd_q[2];
    assign bcd3 = bcd_q[3];

    seg7_to_bcd u_dec (
        .display (display),
        .code    (code_p0),
        .illegal (seg_bad_p0)
    );

    // Classify this cycle's sample and work out what it does to the selected position
    always_comb begin
        cls_p0     = classify_digit(digit);
        pos_p0     = cls_p0.pos;
        sample_p0  = (cls_p0.kind == DK_SAMPLE);
        dig_err_p0 = (cls_p0.kind == DK_BAD);
        vld_p0     = sample_p0 && !seg_bad_p0;
        seg_err_p0 = sample_p0 && seg_bad_p0;
        cnt_nxt_p0 = (code_p0 == cand_q[pos_p0]) ? sat_inc(cnt_q[pos_p0]) : CW'(1);
        commit_p0  = vld_p0 && (cnt_nxt_p0 == CNT_FULL)
                     && ((code_p0 != bcd_q[pos_p0]) || !valid[pos_p0]);
        // The counter reaches TIMEOUT-1 on this edge, or is already parked there
        expire_p0  = !vld_p0 && ((tcnt_q == TO_WARN) || (tcnt_q == TO_LAST));
    end

    // Candidate value and confirmation count per position
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                cand_q[i] <= BCD_BLANK;
                cnt_q[i]  <= '0;
            end
        end else if (vld_p0) begin
            cand_q[pos_p0] <= code_p0;
            cnt_q[pos_p0]  <= cnt_nxt_p0;
        end else if (seg_err_p0 || expire_p0) begin
            // A corrupt segment pattern restarts its own position; a timeout restarts all
            for (int i = 0; i < 4; i++) begin
                if (expire_p0 || (pos_p0 == 2'(i))) begin
                    cnt_q[i] <= '0;
                end
            end
        end
    end

    // Confirmed outputs: commit on full confirmation, drop validity on timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                bcd_q[i] <= BCD_BLANK;
            end
            valid <= '0;
        end else if (commit_p0) begin
            bcd_q[pos_p0] <= code_p0;
            valid[pos_p0] <= 1'b1;
        end else if (expire_p0) begin
            valid <= '0;
        end
    end

    // Inactivity counter: cleared by each legal sample, parks at TIMEOUT-1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt_q <= '0;
            stale  <= 1'b0;
        end else if (vld_p0) begin
            tcnt_q <= '0;
            stale  <= 1'b0;
        end else begin
            if (tcnt_q != TO_LAST) begin
                tcnt_q <= tcnt_q + TW'(1);
            end
            if (expire_p0) begin
                stale <= 1'b1;
            end
        end
    end

    // Single-cycle event pulses; upd_pos keeps the position of the latest update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upd     <= 1'b0;
            upd_pos <= 2'd0;
            err     <= 1'b0;
        end else begin
            upd <= commit_p0;
            err <= dig_err_p0 || seg_err_p0;
            if (commit_p0) begin
                upd_pos <= pos_p0;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed and randomized bench for seg7_scan_capture, checked against a
// behavioural model of the capture rules.
module tb_seg7_scan_capture;

    localparam int CONFIRM = 2;
    localparam int TIMEOUT = 8;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic [3:0] digit   = 4'b1111;
    logic [6:0] display = 7'b1111111;
    logic [3:0] bcd0, bcd1, bcd2, bcd3, valid;
    logic       upd, err, stale;
    logic [1:0] upd_pos;

    seg7_scan_capture #(.CONFIRM(CONFIRM), .TIMEOUT(TIMEOUT)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .digit   (digit),
        .display (display),
        .bcd0    (bcd0),
        .bcd1    (bcd1),
        .bcd2    (bcd2),
        .bcd3    (bcd3),
        .valid   (valid),
        .upd     (upd),
        .upd_pos (upd_pos),
        .err     (err),
        .stale   (stale)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] SEGTAB [10] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
        7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
    };

    int tests = 0;
    int fails = 0;

    // Reference state
    int         m_bcd  [4];
    int         m_cand [4];
    int         m_cnt  [4];
    logic [3:0] m_valid;
    logic       m_stale;
    logic       e_upd, e_err;
    int         e_pos;
    int         idle;
    int         pulse_pos [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // 0..9 for a digit, 15 for blank, -1 for anything else
    function automatic int seg_lookup(input logic [6:0] s);
        if (s == 7'b1111111) return 15;
        for (int k = 0; k < 10; k++) begin
            if (SEGTAB[k] == s) return k;
        end
        return -1;
    endfunction

    function automatic logic [6:0] code_to_seg(input int v);
        if (v < 10) return SEGTAB[v];
        return 7'b1111111;
    endfunction

    function automatic logic [3:0] pos_en(input int p);
        logic [3:0] m;
        m = 4'b1111;
        m[p] = 1'b0;
        return m;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_bcd[k]  = 15;
            m_cand[k] = 15;
            m_cnt[k]  = 0;
        end
        m_valid = 4'b0000;
        m_stale = 1'b0;
        e_upd   = 1'b0;
        e_err   = 1'b0;
        e_pos   = 0;
        idle    = 0;
    endtask

    // Apply the capture rules for one clock edge with inputs d/s
    task automatic model_step(input logic [3:0] d, input logic [6:0] s);
        logic [3:0] lows;
        int p, c;
        bit legal;
        legal = 0;
        e_upd = 1'b0;
        e_err = 1'b0;
        lows  = ~d;
        if (d == 4'b1111) begin
            legal = 0;
        end else if ($countones(lows) == 1) begin
            p = 0;
            for (int k = 0; k < 4; k++) if (lows[k]) p = k;
            c = seg_lookup(s);
            if (c < 0) begin
                e_err = 1'b1;
                m_cnt[p] = 0;
            end else begin
                legal = 1;
                if (c == m_cand[p]) begin
                    m_cnt[p] = (m_cnt[p] + 1 > CONFIRM) ? CONFIRM : m_cnt[p] + 1;
                end else begin
                    m_cand[p] = c;
                    m_cnt[p]  = 1;
                end
                if (m_cnt[p] == CONFIRM && (c != m_bcd[p] || !m_valid[p])) begin
                    m_bcd[p]   = c;
                    m_valid[p] = 1'b1;
                    e_upd      = 1'b1;
                    e_pos      = p;
                end
            end
        end else begin
            e_err = 1'b1;
        end
        if (legal) begin
            idle    = 0;
            m_stale = 1'b0;
        end else begin
            idle++;
            if (idle >= TIMEOUT - 1) begin
                m_stale = 1'b1;
                m_valid = 4'b0000;
                for (int k = 0; k < 4; k++) m_cnt[k] = 0;
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".bcd0"},  bcd0,  m_bcd[0]);
        check({tag, ".bcd1"},  bcd1,  m_bcd[1]);
        check({tag, ".bcd2"},  bcd2,  m_bcd[2]);
        check({tag, ".bcd3"},  bcd3,  m_bcd[3]);
        check({tag, ".valid"}, valid, m_valid);
        check({tag, ".upd"},   upd,   e_upd);
        check({tag, ".err"},   err,   e_err);
        check({tag, ".stale"}, stale, m_stale);
        if (e_upd) check({tag, ".upd_pos"}, upd_pos, e_pos);
    endtask

    // Drive one cycle of inputs, advance the model, then compare after the edge
    task automatic cycle(input string tag, input logic [3:0] d, input logic [6:0] s);
        digit   = d;
        display = s;
        @(posedge clk);
        model_step(d, s);
        #1;
        if (upd) pulse_pos.push_back(int'(upd_pos));
        check_all(tag);
    endtask

    initial begin
        int r, p, n, len;
        int pv [4];
        logic [3:0] d;
        logic [6:0] s;

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        check("reset.bcd0_const", bcd0, 4'hF);
        check("reset.upd_pos", upd_pos, 2'd0);
        rst_n = 1'b1;

        // Normal scan: positions 0/1 alternate with 3 and 7
        pulse_pos.delete();
        for (int i = 0; i < 4; i++) begin
            cycle("scan0", 4'b1110, 7'b0000110);
            cycle("scan1", 4'b1101, 7'b0001111);
        end
        check("scan.bcd0_is3", bcd0, 4'd3);
        check("scan.bcd1_is7", bcd1, 4'd7);
        check("scan.valid", valid, 4'b0011);
        check("scan.pulses", pulse_pos.size(), 2);
        check("scan.first_pos", (pulse_pos.size() > 0) ? pulse_pos[0] : -1, 0);
        check("scan.second_pos", (pulse_pos.size() > 1) ? pulse_pos[1] : -1, 1);

        // Value change on position 0 to 5
        cycle("chg_a", 4'b1110, 7'b0100100);
        check("chg.bcd0_still3", bcd0, 4'd3);
        check("chg.no_upd", upd, 1'b0);
        cycle("chg_b", 4'b1101, 7'b0001111);
        cycle("chg_c", 4'b1110, 7'b0100100);
        check("chg.bcd0_is5", bcd0, 4'd5);
        check("chg.upd", upd, 1'b1);
        check("chg.upd_pos", upd_pos, 2'd0);

        // Illegal enable pattern
        cycle("bad_dig", 4'b1100, 7'b0000110);
        check("bad_dig.err", err, 1'b1);

        // Illegal segment pattern clears the count of position 1
        cycle("seg_a", 4'b1101, 7'b0000100);
        cycle("seg_bad", 4'b1101, 7'b1110000);
        check("seg_bad.err", err, 1'b1);
        cycle("seg_b", 4'b1101, 7'b0000100);
        check("seg_restart.no_upd", upd, 1'b0);
        cycle("seg_c", 4'b1101, 7'b0000100);
        check("seg_restart.upd", upd, 1'b1);
        check("seg_restart.bcd1", bcd1, 4'd9);

        // Blank on position 2
        cycle("blank_a", 4'b1011, 7'b1111111);
        cycle("blank_b", 4'b1011, 7'b1111111);
        check("blank.bcd2", bcd2, 4'hF);
        check("blank.valid2", valid[2], 1'b1);
        check("blank.upd", upd, 1'b1);
        check("blank.upd_pos", upd_pos, 2'd2);

        // Timeout: stale exactly 7 idle cycles after the last legal sample
        for (int i = 1; i <= 10; i++) begin
            cycle("idle", 4'b1111, 7'b1111111);
            check("idle.stale_edge", stale, (i >= TIMEOUT - 1) ? 1'b1 : 1'b0);
        end
        check("timeout.valid", valid, 4'b0000);
        check("timeout.bcd0_kept", bcd0, 4'd5);
        check("timeout.bcd1_kept", bcd1, 4'd9);
        cycle("wake", 4'b0111, 7'b0000000);
        check("wake.stale", stale, 1'b0);

        // Randomized traffic
        for (int k = 0; k < 4; k++) pv[k] = $urandom_range(0, 10);
        for (n = 0; n < 400; n++) begin
            r = $urandom_range(0, 99);
            if (r < 65) begin
                p = $urandom_range(0, 3);
                if ($urandom_range(0, 99) < 20) pv[p] = $urandom_range(0, 10);
                cycle("rnd_smp", pos_en(p), code_to_seg(pv[p]));
            end else if (r < 78) begin
                len = $urandom_range(1, 9);
                for (int j = 0; j < len; j++) begin
                    s = 7'($urandom);
                    cycle("rnd_idle", 4'b1111, s);
                end
            end else if (r < 90) begin
                d = 4'($urandom);
                if (d == 4'b1111 || $countones(~d) == 1) d = 4'b1100;
                cycle("rnd_baddig", d, code_to_seg(pv[0]));
            end else begin
                p = $urandom_range(0, 3);
                s = 7'($urandom);
                if (seg_lookup(s) >= 0) s = 7'b1110000;
                cycle("rnd_badseg", pos_en(p), s);
            end
        end

        // Reset in the middle of a confirmation
        cycle("mid_a", 4'b1110, 7'b0000000);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle("post_a", 4'b1110, 7'b0000000);
        check("post.no_upd", upd, 1'b0);
        cycle("post_b", 4'b1110, 7'b0000000);
        check("post.upd", upd, 1'b1);
        check("post.bcd0", bcd0, 4'd8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
